// File: rtl/core_pkg.sv
// core_pkg: shared decode constants, register-file sizing and the issue FSM
// state type for the issue scoreboard slice.
// Instruction layout: opcode[31:26] rd[25:22] rs1[21:18] rs2[17:14] imm[13:0].
package core_pkg;

    localparam int unsigned NREG_DEFAULT = 16;
    localparam int unsigned REG_IDX_W    = 4;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_MSB = 21;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_MSB = 17;
    localparam int unsigned RS2_LSB = 14;
    localparam int unsigned IMM_MSB = 13;
    localparam int unsigned IMM_LSB = 0;

    // opcode bit that marks an instruction as writing rd
    localparam int unsigned OPC_WRITE_BIT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    // R0 and R15 are hardwired: never written, never tracked
    function automatic logic reg_writable(input logic [REG_IDX_W-1:0] idx);
        return (idx != '0) && (idx != '1);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: fetch handshake, issue handshake, write-back and
// status signals of the issue scoreboard.
//   master : fetch/write-back side (drives in_valid, in_instr, out_ready, wb_*)
//   slave  : scoreboard side (drives in_ready, out_*, busy_mask, stall_count)
interface issue_scoreboard_if;

    logic                                 in_valid;
    logic                                 in_ready;
    logic [31:0]                          in_instr;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [core_pkg::REG_IDX_W-1:0]       out_rs1;
    logic [core_pkg::REG_IDX_W-1:0]       out_rs2;
    logic [core_pkg::REG_IDX_W-1:0]       out_rd;
    logic [5:0]                           out_opcode;
    logic [13:0]                          out_imm;
    logic                                 out_reg_write;
    logic                                 wb_valid;
    logic [core_pkg::REG_IDX_W-1:0]       wb_rd;
    logic [core_pkg::NREG_DEFAULT-1:0]    busy_mask;
    logic [15:0]                          stall_count;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_opcode,
               out_imm, out_reg_write, busy_mask, stall_count
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_opcode,
               out_imm, out_reg_write, busy_mask, stall_count
    );

endinterface

// File: rtl/scoreboard_bits.sv
// scoreboard_bits: pending-write bit per architectural register.
//   i_set_en/i_set_idx : mark register pending (set wins over same-cycle clear)
//   i_clr_en/i_clr_idx : write-back completion; index 0 and NREG-1 ignored
//   o_busy             : registered pending mask
//   o_hazard_view      : mask used for hazard checks; with SCOREBOARD_BYPASS_EN
//                        defined the register completing this cycle is masked off
module scoreboard_bits #(
    parameter  int unsigned NREG  = core_pkg::NREG_DEFAULT,
    localparam int unsigned IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set_en,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    output logic [NREG-1:0]  o_busy,
    output logic [NREG-1:0]  o_hazard_view
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_clr_vec;

    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (i_set_en) begin
            w_set_vec[i_set_idx] = 1'b1;
        end
        if (i_clr_en && (i_clr_idx != '0) && (i_clr_idx != IDX_W'(NREG - 1))) begin
            w_clr_vec[i_clr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
        end
    end

    assign o_busy = r_busy;

`ifdef SCOREBOARD_BYPASS_EN
    assign o_hazard_view = r_busy & ~w_clr_vec;
`else
    assign o_hazard_view = r_busy;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: single-issue decode stage with RAW/WAW scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : issue_scoreboard_if.slave (fetch in_*, issue out_*, wb_*,
//                busy_mask, stall_count)
// Optional feature: define SCOREBOARD_BYPASS_EN to let a dependent instruction
// issue in the same cycle as the write-back that clears its hazard.
module issue_scoreboard #(
    parameter int unsigned NREG = core_pkg::NREG_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_scoreboard_if.slave   bus
);

    import core_pkg::*;

    logic [5:0]           w_opcode;
    logic [REG_IDX_W-1:0] w_rd;
    logic [REG_IDX_W-1:0] w_rs1;
    logic [REG_IDX_W-1:0] w_rs2;
    logic [13:0]          w_imm;
    logic                 w_reg_write;
    logic [NREG-1:0]      w_busy;
    logic [NREG-1:0]      w_hazard_view;
    logic                 w_hazard;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_stall;

    logic                 r_out_valid;
    logic [5:0]           r_opcode;
    logic [REG_IDX_W-1:0] r_rd;
    logic [REG_IDX_W-1:0] r_rs1;
    logic [REG_IDX_W-1:0] r_rs2;
    logic [13:0]          r_imm;
    logic                 r_reg_write;
    logic [15:0]          r_stall_count;

    state_e               r_state;
    state_e               w_state_nxt;

    assign w_opcode    = bus.in_instr[OPC_MSB:OPC_LSB];
    assign w_rd        = bus.in_instr[RD_MSB:RD_LSB];
    assign w_rs1       = bus.in_instr[RS1_MSB:RS1_LSB];
    assign w_rs2       = bus.in_instr[RS2_MSB:RS2_LSB];
    assign w_imm       = bus.in_instr[IMM_MSB:IMM_LSB];
    assign w_reg_write = w_opcode[OPC_WRITE_BIT] && reg_writable(w_rd);

    scoreboard_bits #(
        .NREG (NREG)
    ) u_bits (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_set_en      (w_accept && w_reg_write),
        .i_set_idx     (w_rd),
        .i_clr_en      (bus.wb_valid),
        .i_clr_idx     (bus.wb_rd),
        .o_busy        (w_busy),
        .o_hazard_view (w_hazard_view)
    );

    assign w_hazard   = w_hazard_view[w_rs1] || w_hazard_view[w_rs2] ||
                        (w_reg_write && w_hazard_view[w_rd]);
    assign w_in_ready = !w_hazard && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && bus.out_ready;
    // only hazard cycles count; back-pressure from out_ready alone does not
    assign w_stall    = bus.in_valid && w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept)     w_state_nxt = ST_HOLD;
                else if (w_stall) w_state_nxt = ST_STALL;
            end
            ST_HOLD: begin
                if (w_accept)     w_state_nxt = ST_HOLD;
                else if (w_stall) w_state_nxt = ST_STALL;
                else if (w_xfer)  w_state_nxt = ST_IDLE;
            end
            ST_STALL: begin
                // an older instruction may still sit in the output stage
                if (w_accept)           w_state_nxt = ST_HOLD;
                else if (!bus.in_valid) w_state_nxt = (r_out_valid && !w_xfer) ? ST_HOLD : ST_IDLE;
                else if (!w_hazard)     w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_opcode;
            r_rd        <= w_rd;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_imm       <= w_imm;
            r_reg_write <= w_reg_write;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_opcode    = r_opcode;
    assign bus.out_rd        = r_rd;
    assign bus.out_rs1       = r_rs1;
    assign bus.out_rs2       = r_rs2;
    assign bus.out_imm       = r_imm;
    assign bus.out_reg_write = r_reg_write;
    assign bus.busy_mask     = w_busy;
    assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed stimulus for issue_scoreboard; expected issue
// packets are queued at drive time and checked by a separate output monitor.
// Honours SCOREBOARD_BYPASS_EN for the write-back-to-issue latency.
module tb_issue_scoreboard;

    logic clk = 1'b0;
    logic rst_n;

    issue_scoreboard_if bus();

    issue_scoreboard #(
        .NREG (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef SCOREBOARD_BYPASS_EN
    localparam int unsigned BYP = 1;
`else
    localparam int unsigned BYP = 0;
`endif

    typedef logic [39:0] w40_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [13:0] imm;
        logic        rw;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_stall;
    logic        r0;

    task automatic check(input string name, input w40_t act, input w40_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [13:0] imm, input logic rw,
                        input bit track);
        exp_t e;
        bus.in_instr = {op, rd, rs1, rs2, imm};
        bus.in_valid = 1'b1;
        e = {op, rd, rs1, rs2, imm, rw};
        if (track) exp_q.push_back(e);
    endtask

    // output monitor: every transfer must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got = {bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_reg_write};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_unexpected: got 0x%0h expected no issue", got);
            end else begin
                want = exp_q.pop_front();
                check("issue_packet", w40_t'(got), w40_t'(want));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.out_ready = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        exp_stall    = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", w40_t'(bus.out_valid), w40_t'(0));
        check("rst_busy", w40_t'(bus.busy_mask), w40_t'(0));
        check("rst_stall", w40_t'(bus.stall_count), w40_t'(0));
        check("rst_out_rd", w40_t'(bus.out_rd), w40_t'(0));
        check("rst_out_rw", w40_t'(bus.out_reg_write), w40_t'(0));
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // basic issue: rd=3 writer
        step();
        send(6'h20, 4'd3, 4'd1, 4'd2, 14'h0123, 1'b1, 1'b1);
        @(negedge clk);
        check("a_in_ready", w40_t'(bus.in_ready), w40_t'(1));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("a_out_valid", w40_t'(bus.out_valid), w40_t'(1));
        check("a_busy", w40_t'(bus.busy_mask), w40_t'(16'h0008));

        // RAW on R3: stall three cycles, then write-back releases it
        step();
        send(6'h20, 4'd4, 4'd3, 4'd0, 14'h0004, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("raw_in_ready", w40_t'(bus.in_ready), w40_t'(0));
            check("raw_stall", w40_t'(bus.stall_count), w40_t'(exp_stall));
            step();
            exp_stall = exp_stall + 16'd1;
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd3;
        @(negedge clk);
        r0 = bus.in_ready;
        check("wb_in_ready", w40_t'(r0), w40_t'(BYP));
        check("wb_stall", w40_t'(bus.stall_count), w40_t'(exp_stall));
        step();
        bus.wb_valid = 1'b0;
        exp_stall = exp_stall + ((BYP != 0) ? 16'd0 : 16'd1);
        if (!r0) begin
            @(negedge clk);
            check("wb_in_ready_late", w40_t'(bus.in_ready), w40_t'(1));
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("raw_out_valid", w40_t'(bus.out_valid), w40_t'(1));
        check("raw_busy", w40_t'(bus.busy_mask), w40_t'(16'h0010));
        check("raw_stall_final", w40_t'(bus.stall_count), w40_t'(exp_stall));
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd4;
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check("clr_busy", w40_t'(bus.busy_mask), w40_t'(0));

        // back-to-back non-writers: rd=15, rd=0, opcode[5]=0
        step();
        send(6'h21, 4'd15, 4'd5, 4'd6, 14'h1111, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_ready0", w40_t'(bus.in_ready), w40_t'(1));
        step();
        send(6'h3F, 4'd0, 4'd7, 4'd8, 14'h2222, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_ready1", w40_t'(bus.in_ready), w40_t'(1));
        step();
        send(6'h05, 4'd7, 4'd9, 4'd10, 14'h3333, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_ready2", w40_t'(bus.in_ready), w40_t'(1));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_valid", w40_t'(bus.out_valid), w40_t'(1));
        check("b2b_busy", w40_t'(bus.busy_mask), w40_t'(0));

        // back-pressure: output held for 5 cycles, no stall counted
        step();
        bus.out_ready = 1'b0;
        send(6'h22, 4'd6, 4'd1, 4'd2, 14'h2AAA, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_ready_first", w40_t'(bus.in_ready), w40_t'(1));
        step();
        send(6'h23, 4'd7, 4'd8, 4'd9, 14'h0777, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", w40_t'(bus.in_ready), w40_t'(0));
            check("bp_out_valid", w40_t'(bus.out_valid), w40_t'(1));
            check("bp_out_rd", w40_t'(bus.out_rd), w40_t'(6));
            check("bp_out_opcode", w40_t'(bus.out_opcode), w40_t'(6'h22));
            check("bp_out_imm", w40_t'(bus.out_imm), w40_t'(14'h2AAA));
            check("bp_stall", w40_t'(bus.stall_count), w40_t'(exp_stall));
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", w40_t'(bus.in_ready), w40_t'(1));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_out_valid2", w40_t'(bus.out_valid), w40_t'(1));
        check("bp_busy", w40_t'(bus.busy_mask), w40_t'(16'h00C0));
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd6;
        step();
        bus.wb_rd    = 4'd7;
        step();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check("bp_clr_busy", w40_t'(bus.busy_mask), w40_t'(0));

        // set and clear of R5 in the same cycle: set wins
        step();
        send(6'h20, 4'd5, 4'd1, 4'd2, 14'h0005, 1'b1, 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd5;
        @(negedge clk);
        check("sc_in_ready", w40_t'(bus.in_ready), w40_t'(1));
        step();
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check("sc_busy", w40_t'(bus.busy_mask), w40_t'(16'h0020));

        // WAW on pending R5
        step();
        send(6'h20, 4'd5, 4'd1, 4'd2, 14'h0055, 1'b1, 1'b0);
        @(negedge clk);
        check("waw_in_ready", w40_t'(bus.in_ready), w40_t'(0));
        step();
        bus.in_valid = 1'b0;
        exp_stall = exp_stall + 16'd1;
        @(negedge clk);
        check("waw_stall", w40_t'(bus.stall_count), w40_t'(exp_stall));

        // asynchronous reset while holding an instruction
        step();
        bus.out_ready = 1'b0;
        send(6'h20, 4'd9, 4'd1, 4'd2, 14'h0009, 1'b1, 1'b1);
        @(negedge clk);
        check("hold_in_ready", w40_t'(bus.in_ready), w40_t'(1));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("hold_out_valid", w40_t'(bus.out_valid), w40_t'(1));
        check("hold_busy", w40_t'(bus.busy_mask), w40_t'(16'h0220));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", w40_t'(bus.out_valid), w40_t'(0));
        check("arst_busy", w40_t'(bus.busy_mask), w40_t'(0));
        check("arst_stall", w40_t'(bus.stall_count), w40_t'(0));
        check("arst_out_rd", w40_t'(bus.out_rd), w40_t'(0));
        check("arst_out_opcode", w40_t'(bus.out_opcode), w40_t'(0));
        check("arst_out_imm", w40_t'(bus.out_imm), w40_t'(0));
        check("arst_out_rw", w40_t'(bus.out_reg_write), w40_t'(0));
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(6'h20, 4'd2, 4'd3, 4'd4, 14'h0002, 1'b1, 1'b1);
        @(negedge clk);
        check("post_in_ready", w40_t'(bus.in_ready), w40_t'(1));
        check("post_out_valid0", w40_t'(bus.out_valid), w40_t'(0));
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_out_valid1", w40_t'(bus.out_valid), w40_t'(1));
        check("post_busy", w40_t'(bus.busy_mask), w40_t'(16'h0004));
        check("post_stall", w40_t'(bus.stall_count), w40_t'(0));
        step();
        step();
        @(negedge clk);
        check("queue_drained", w40_t'(exp_q.size()), w40_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 16, number of architectural registers (index width 4).
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have in_valid / in_ready  input / output  1 / 1  instruction handshake from fetch.
REQ-005 SHALL have in_instr  input  32  instruction: opcode[31:26], rd[25:22], rs1[21:18], rs2[17:14], imm[13:0].
REQ-006 SHALL have out_valid / out_ready  output / input  1 / 1  issue handshake toward the register bank.
REQ-007 SHALL have out_rs1, out_rs2, out_rd  output  4 each  decoded register addresses.
REQ-008 SHALL have out_opcode  output  6, out_imm  output  14, out_reg_write  output  1 (instruction writes rd).
REQ-009 SHALL have wb_valid  input  1, wb_rd  input  4  write-back completion; clears the pending bit of wb_rd.
REQ-010 SHALL have busy_mask  output  16  current scoreboard, bit n = register n write pending.
REQ-011 SHALL have stall_count  output  16  saturating count of hazard-stall cycles.

Function
REQ-012 SHALL set out_reg_write = opcode[5] AND rd not 0 AND rd not 15 (R0, R15 not writable).
REQ-013 SHALL declare a hazard when rs1 or rs2 is pending, or when out_reg_write is set and rd is pending (WAW).
REQ-014 SHALL drive in_ready = no hazard AND (out_valid=0 OR out_ready=1); combinational, no dependence on in_valid.
REQ-015 SHALL register accepted decode fields into the output stage: out_valid rises the cycle after acceptance (latency 1).
REQ-016 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-017 SHALL support back-to-back issue: accept and output transfer in the same cycle gives one instruction per cycle.
REQ-018 SHALL use FSM states IDLE (out_valid=0), HOLD (out_valid=1), STALL (in_valid=1 with hazard); IDLE->HOLD on accept; HOLD->IDLE on transfer without new accept; any->STALL on hazard with in_valid; STALL->HOLD on accept once the hazard clears; STALL->IDLE when in_valid drops.
REQ-019 SHALL set busy_mask[rd] on acceptance of a writing instruction.
REQ-020 SHALL clear busy_mask[wb_rd] when wb_valid=1; wb_rd of 0 or 15 is ignored.
REQ-021 SHALL let set win when set and clear target the same register in the same cycle.
REQ-022 SHALL increment stall_count each cycle with in_valid=1 and hazard=1, saturating at 0xFFFF.
REQ-023 SHALL not count cycles blocked only by out_ready=0.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of clk: busy_mask=0, out_valid=0, out_rs1/out_rs2/out_rd/out_opcode/out_imm/out_reg_write=0, stall_count=0, FSM=IDLE.
REQ-025 SHALL discard any held or in-flight instruction when reset asserts mid-operation; the first acceptance is the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro SCOREBOARD_BYPASS_EN.
REQ-027 SHALL, with SCOREBOARD_BYPASS_EN defined, evaluate hazards against busy_mask with the current-cycle wb_rd bit masked off, so a dependent instruction issues in the same cycle as its write-back.
REQ-028 SHALL, without the macro, evaluate hazards on registered busy_mask only, so the dependent instruction issues one cycle after write-back.

Structure
REQ-029 SHALL place the opcode/rd/rs1/rs2/imm bit-position constants, the NREG default, and the FSM state enum in shared package core_pkg.
REQ-030 SHALL isolate the pending-bit array with its set/clear/bypass logic in one sub-module, scoreboard_bits.

Verification
REQ-031 SHALL pass: reset, then instr opcode=0x20, rd=3, rs1=1, rs2=2 with out_ready=1 -> out_valid next cycle, out_rd=3, out_reg_write=1, busy_mask=0x0008.
REQ-032 SHALL pass: next instr rs1=3 while R3 pending -> in_ready=0, stall_count increments per cycle; wb_valid with wb_rd=3 -> issue the same cycle with BYPASS_EN, one cycle later without.
REQ-033 SHALL pass: writing instr with rd=15 or rd=0 -> out_reg_write=0, busy_mask unchanged.
REQ-034 SHALL pass: out_ready held 0 for 5 cycles with in_valid=1 -> out_* stable, in_ready=0, stall_count unchanged.
REQ-035 SHALL pass: accept rd=5 with wb_valid, wb_rd=5 in the same cycle -> busy_mask[5]=1.
REQ-036 SHALL pass: rst_n pulsed low mid-HOLD between edges -> out_valid=0 and busy_mask=0 before the next clk edge.
